ucq_arbiter: RTL and testbench

- Sequences the shared unit-clause queue (8-entry, 9-bit literal FIFO with combinational head read).
- Arbitrates round-robin among NUM_REQ clause engines that produce unit literals and pushes the winner into the queue.
- Pops literals into a registered valid/ready output stage for the propagation engine.
- Provides a flush/drain sequence used on conflict/backtrack.

---
 rtl/ucq_arbiter.sv | 140 ++++++++++++++
 tb/tb_ucq_arbiter.sv | 566 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucq_arbiter.sv
// ucq_arbiter: round-robin producer arbiter, pop/output stage and
// flush/drain sequencer for the shared unit-clause queue.
module ucq_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LIT_W   = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][LIT_W-1:0] req_lit,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ucq_push,
  output logic [LIT_W-1:0]              ucq_data,
  output logic                          ucq_pop,
  input  logic [LIT_W-1:0]              ucq_lit,
  input  logic                          ucq_full,
  input  logic                          ucq_empty,
  output logic                          eng_valid,
  output logic [LIT_W-1:0]              eng_lit,
  input  logic                          eng_ready,
  input  logic                          flush,
  output logic                          flush_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_next;
  logic [IW-1:0]    r_ptr;
  logic             r_prio;
  logic             r_eng_valid;
  logic [LIT_W-1:0] r_eng_lit;

  logic             w_found;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_win_nxt;
  logic             w_push_cand;
  logic             w_pop_cand;
  logic             w_contest;
  logic             w_push;
  logic             w_pop_run;

  // first valid requester at or above the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int d = 0; d < NUM_REQ; d++) begin
      int v_idx;
      v_idx = (int'(r_ptr) + d) % NUM_REQ;
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_win   = IW'(v_idx);
      end
    end
  end

  assign w_win_nxt = (w_win == IW'(NUM_REQ - 1))
                   ? '0 : w_win + 1'b1;

  always_comb begin
    w_next      = r_state;
    w_push_cand = 1'b0;
    w_pop_cand  = 1'b0;
    w_contest   = 1'b0;
    w_push      = 1'b0;
    w_pop_run   = 1'b0;
    req_ready   = '0;
    ucq_push    = 1'b0;
    ucq_data    = '0;
    grant_id    = '0;
    ucq_pop     = 1'b0;
    flush_done  = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_RUN: begin
          w_push_cand = w_found & ~ucq_full & ~flush;
          w_pop_cand  = ~ucq_empty & ~flush
                      & (~r_eng_valid | eng_ready);
          // r_prio=0 lets the pop side win a contested cycle
          w_contest   = w_push_cand & w_pop_cand;
          w_push      = w_push_cand & (~w_pop_cand | r_prio);
          w_pop_run   = w_pop_cand & (~w_push_cand | ~r_prio);
          if (w_push) begin
            req_ready[w_win] = 1'b1;
            ucq_push         = 1'b1;
            ucq_data         = req_lit[w_win];
            grant_id         = w_win;
          end
          ucq_pop = w_pop_run;
          busy    = r_eng_valid | ~ucq_empty;
          if (flush) w_next = S_DRAIN;
        end
        S_DRAIN: begin
          ucq_pop    = ~ucq_empty;
          flush_done = ucq_empty;
          busy       = 1'b1;
          if (ucq_empty) w_next = S_RUN;
        end
        default: w_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_prio      <= 1'b0;
      r_eng_valid <= 1'b0;
      r_eng_lit   <= '0;
    end else begin
      if (w_push)    r_ptr  <= w_win_nxt;
      if (w_contest) r_prio <= ~r_prio;
      if (r_state == S_RUN && flush) begin
        r_eng_valid <= 1'b0;
        r_eng_lit   <= '0;
      end else if (w_pop_run) begin
        r_eng_valid <= 1'b1;
        r_eng_lit   <= ucq_lit;
      end else if (eng_ready) begin
        r_eng_valid <= 1'b0;
      end
    end
  end

  assign eng_valid = r_eng_valid;
  assign eng_lit   = r_eng_lit;

endmodule

// File: tb/tb_ucq_arbiter.sv
// tb_ucq_arbiter: randomized and directed bench for ucq_arbiter with
// a behavioural 8-deep queue and a rule-level reference model.
module tb_ucq_arbiter;
  localparam int N     = 4;
  localparam int W     = 9;
  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0][W-1:0]   req_lit;
  logic [N-1:0]          req_ready;
  logic                  ucq_push;
  logic [W-1:0]          ucq_data;
  logic                  ucq_pop;
  logic [W-1:0]          ucq_lit;
  logic                  ucq_full;
  logic                  ucq_empty;
  logic                  eng_valid;
  logic [W-1:0]          eng_lit;
  logic                  eng_ready;
  logic                  flush;
  logic                  flush_done;
  logic [1:0]            grant_id;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fifo[$];

  bit m_drain    = 0;
  int m_ptr      = 0;
  bit m_popfirst = 1;
  bit m_ev       = 0;
  int m_el       = 0;

  logic [N-1:0] e_ready;
  bit e_push, e_pop, e_done, e_busy, e_contest;
  int e_data, e_gid, e_win;

  always #5 clk = ~clk;

  ucq_arbiter #(.NUM_REQ(N), .LIT_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_lit(req_lit),
    .req_ready(req_ready),
    .ucq_push(ucq_push), .ucq_data(ucq_data),
    .ucq_pop(ucq_pop), .ucq_lit(ucq_lit),
    .ucq_full(ucq_full), .ucq_empty(ucq_empty),
    .eng_valid(eng_valid), .eng_lit(eng_lit),
    .eng_ready(eng_ready),
    .flush(flush), .flush_done(flush_done),
    .grant_id(grant_id), .busy(busy)
  );

  // requesters must hold req_lit while waiting for a grant
  logic [N-1:0]        a_pv, a_pr;
  logic [N-1:0][W-1:0] a_pl;
  always @(posedge clk) begin
    if (rst !== 1'b1)
      for (int i = 0; i < N; i++)
        if (a_pv[i] && !a_pr[i] && req_valid[i]
            && req_lit[i] !== a_pl[i])
          $error("req_lit unstable on requester %0d", i);
    a_pv <= req_valid;
    a_pr <= req_ready;
    a_pl <= req_lit;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic refresh();
    ucq_full  = (fifo.size() == DEPTH);
    ucq_empty = (fifo.size() == 0);
    ucq_lit   = '0;
    if (fifo.size() > 0) ucq_lit = fifo[0];
  endtask

  // expected combinational outputs from the arbitration rules
  task automatic model_eval();
    int  cnt;
    bit  cpush, cpop;
    cnt = fifo.size();
    e_ready = '0; e_push = 0; e_pop = 0; e_done = 0;
    e_busy = 0; e_data = 0; e_gid = 0; e_contest = 0;
    e_win = -1;
    if (rst) return;
    if (m_drain) begin
      e_pop  = (cnt > 0);
      e_done = (cnt == 0);
      e_busy = 1;
      return;
    end
    for (int d = 0; d < N; d++)
      if (e_win < 0 && req_valid[(m_ptr + d) % N])
        e_win = (m_ptr + d) % N;
    cpush = (e_win >= 0) && (cnt < DEPTH) && !flush;
    cpop  = (cnt > 0) && (!m_ev || eng_ready) && !flush;
    e_contest = cpush && cpop;
    e_push = e_contest ? !m_popfirst : cpush;
    e_pop  = e_contest ? m_popfirst : cpop;
    if (e_push) begin
      e_ready = N'(1) << e_win;
      e_data  = int'(req_lit[e_win]);
      e_gid   = e_win;
    end
    e_busy = m_ev || (cnt > 0);
  endtask

  task automatic model_update();
    if (rst) begin
      m_drain = 0; m_ptr = 0; m_popfirst = 1;
      m_ev = 0; m_el = 0;
      return;
    end
    if (m_drain) begin
      if (fifo.size() == 0) m_drain = 0;
      return;
    end
    if (flush) begin
      m_drain = 1; m_ev = 0; m_el = 0;
      return;
    end
    if (e_push) m_ptr = (e_win + 1) % N;
    if (e_contest) m_popfirst = !m_popfirst;
    if (e_pop) begin
      m_ev = 1;
      m_el = int'(fifo[0]);
    end else if (eng_ready) begin
      m_ev = 0;
    end
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  // advance one clock: model, then the queue reacting to the DUT
  task automatic tick();
    bit           p, o;
    logic [W-1:0] d;
    model_eval();
    p = ucq_push;
    o = ucq_pop;
    d = ucq_data;
    model_update();
    @(posedge clk);
    #1;
    if (rst) begin
      fifo.delete();
    end else if (o && fifo.size() > 0) begin
      void'(fifo.pop_front());
    end else if (p && fifo.size() < DEPTH) begin
      fifo.push_back(d);
    end
    refresh();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; flush = 0; eng_ready = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    req_valid = '1;
    for (int i = 0; i < N; i++) req_lit[i] = W'($urandom);
    eng_ready = 1; flush = 1;
    fifo.push_back(W'($urandom));
    fifo.push_back(W'($urandom));
    refresh();
    settle();
    checks++;
    if ({req_ready, ucq_push, ucq_pop, flush_done, busy,
         grant_id, ucq_data} !== '0) begin
      failures++;
      $display("FAIL reset_comb: ready=%b push=%b pop=%b done=%b busy=%b want all 0",
               req_ready, ucq_push, ucq_pop, flush_done, busy);
    end
    checks++;
    if (eng_valid !== 1'b0 || eng_lit !== '0) begin
      failures++;
      $display("FAIL reset_out: eng_valid=%b eng_lit=%h want 0/000",
               eng_valid, eng_lit);
    end
    tick();
    rst = 0; req_valid = '0; flush = 0; eng_ready = 0;
    settle();
    checks++;
    if (busy !== 1'b0 || eng_valid !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b eng_valid=%b ready=%b want 0",
               busy, eng_valid, req_ready);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = '1;
    req_lit[0] = 9'h011; req_lit[1] = 9'h022;
    req_lit[2] = 9'h033; req_lit[3] = 9'h044;
    eng_ready = 1;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      settle();
      checks++;
      if (req_ready !== e_ready || ucq_push !== e_push
          || ucq_pop !== e_pop) begin
        failures++;
        $display("FAIL rr_handshake: ready=%b push=%b pop=%b want %b %b %b",
                 req_ready, ucq_push, ucq_pop, e_ready, e_push, e_pop);
      end
      if (ucq_push) begin
        checks++;
        if (grant_id !== 2'(e_gid) || ucq_data !== W'(e_data)) begin
          failures++;
          $display("FAIL rr_grant: id=%0d data=%h want %0d %h",
                   grant_id, ucq_data, e_gid, e_data);
        end
        order.push_back(int'(grant_id));
      end
      checks++;
      if (ucq_pop && ucq_empty) begin
        failures++;
        $display("FAIL rr_pop_empty: pop=1 while empty, want 0");
      end
      tick();
    end
    checks++;
    if (order.size() != 5) begin
      failures++;
      $display("FAIL rr_count: pushes=%0d want 5", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != exp_ord[i]) begin
        failures++;
        $display("FAIL rr_order[%0d]: got %0d want %0d",
                 i, order[i], exp_ord[i]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_full();
    bit g;
    int npush = 0;
    int npop  = 0;
    do_reset();
    req_valid = 4'b0010;
    req_lit[1] = W'($urandom);
    for (int c = 0; c < 40 && fifo.size() < DEPTH; c++) begin
      settle();
      g = req_ready[1];
      tick();
      if (g) req_lit[1] = W'($urandom);
    end
    settle();
    checks++;
    if (ucq_full !== 1'b1 || req_ready !== '0 || ucq_push !== 1'b0) begin
      failures++;
      $display("FAIL full_backpressure: full=%b ready=%b push=%b want 1 0 0",
               ucq_full, req_ready, ucq_push);
    end
    tick();
    eng_ready = 1;
    for (int c = 0; c < 16; c++) begin
      settle();
      checks++;
      if (ucq_push && ucq_pop) begin
        failures++;
        $display("FAIL full_both: push=1 pop=1 want not both");
      end
      checks++;
      if (req_ready !== e_ready || ucq_push !== e_push
          || ucq_pop !== e_pop) begin
        failures++;
        $display("FAIL full_handshake: ready=%b push=%b pop=%b want %b %b %b",
                 req_ready, ucq_push, ucq_pop, e_ready, e_push, e_pop);
      end
      if (ucq_push) npush++;
      if (ucq_pop) npop++;
      g = req_ready[1];
      tick();
      if (g) req_lit[1] = W'($urandom);
    end
    checks++;
    if (npush < 4 || npop < 4) begin
      failures++;
      $display("FAIL full_alternate: pushes=%0d pops=%0d want >=4 each",
               npush, npop);
    end
    req_valid = '0;
  endtask

  task automatic test_contested();
    logic [W-1:0] sb[$];
    int ncont = 0;
    int nout  = 0;
    bit g;
    do_reset();
    eng_ready = 1;
    req_valid = 4'b0001;
    req_lit[0] = W'($urandom);
    for (int c = 0; c < 24; c++) begin
      settle();
      if (e_contest) begin
        checks++;
        if (ucq_pop !== (ncont % 2 == 0)
            || ucq_push !== (ncont % 2 == 1)) begin
          failures++;
          $display("FAIL contest_alt[%0d]: pop=%b push=%b want pop=%0d",
                   ncont, ucq_pop, ucq_push, ncont % 2 == 0);
        end
        ncont++;
      end
      if (eng_valid && eng_ready) begin
        checks++;
        if (sb.size() == 0 || eng_lit !== sb[0]) begin
          failures++;
          $display("FAIL contest_order: eng_lit=%h want %h",
                   eng_lit, sb.size() ? sb[0] : '0);
        end
        if (sb.size() > 0) void'(sb.pop_front());
        nout++;
      end
      if (ucq_push && !ucq_pop) sb.push_back(ucq_data);
      g = req_ready[0];
      tick();
      if (g) req_lit[0] = W'($urandom);
    end
    checks++;
    if (ncont < 6 || nout < 6) begin
      failures++;
      $display("FAIL contest_count: contested=%0d outputs=%0d want >=6",
               ncont, nout);
    end
    req_valid = '0;
  endtask

  task automatic test_latency();
    do_reset();
    eng_ready = 1;
    req_valid = 4'b0001;
    req_lit[0] = 9'h1A5;
    settle();
    checks++;
    if (ucq_push !== 1'b1 || ucq_data !== 9'h1A5
        || req_ready !== 4'b0001 || ucq_pop !== 1'b0) begin
      failures++;
      $display("FAIL lat_push: push=%b data=%h ready=%b pop=%b want 1 1a5 0001 0",
               ucq_push, ucq_data, req_ready, ucq_pop);
    end
    tick();
    req_valid = '0;
    settle();
    checks++;
    if (ucq_pop !== 1'b1 || eng_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_pop: pop=%b eng_valid=%b want 1 0",
               ucq_pop, eng_valid);
    end
    tick();
    settle();
    checks++;
    if (eng_valid !== 1'b1 || eng_lit !== 9'h1A5 || ucq_pop !== 1'b0) begin
      failures++;
      $display("FAIL lat_out: eng_valid=%b eng_lit=%h pop=%b want 1 1a5 0",
               eng_valid, eng_lit, ucq_pop);
    end
    tick();
    settle();
    checks++;
    if (eng_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_clear: eng_valid=%b want 0", eng_valid);
    end
  endtask

  task automatic test_flush();
    bit g;
    int npop = 0;
    int ndone = 0;
    bit resumed = 0;
    do_reset();
    req_valid = 4'b1000;
    req_lit[3] = W'($urandom);
    for (int c = 0; c < 30 && fifo.size() < 5; c++) begin
      settle();
      g = req_ready[3];
      tick();
      if (g) req_lit[3] = W'($urandom);
    end
    checks++;
    if (fifo.size() != 5 || eng_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_setup: queued=%0d eng_valid=%b want 5 1",
               fifo.size(), eng_valid);
    end
    flush = 1;
    settle();
    checks++;
    if (req_ready !== '0 || ucq_push !== 1'b0 || ucq_pop !== 1'b0
        || flush_done !== 1'b0) begin
      failures++;
      $display("FAIL flush_entry: ready=%b push=%b pop=%b done=%b want 0",
               req_ready, ucq_push, ucq_pop, flush_done);
    end
    tick();
    for (int c = 0; c < 20 && !resumed; c++) begin
      flush = (c == 1);
      settle();
      if (ndone > 0) begin
        checks++;
        if (req_ready !== 4'b1000 || ucq_push !== 1'b1) begin
          failures++;
          $display("FAIL flush_resume: ready=%b push=%b want 1000 1",
                   req_ready, ucq_push);
        end
        resumed = 1;
      end else begin
        checks++;
        if (eng_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b1
            || ucq_pop !== e_pop || flush_done !== e_done) begin
          failures++;
          $display("FAIL flush_drain: ev=%b ready=%b busy=%b pop=%b done=%b want 0 0 1 %b %b",
                   eng_valid, req_ready, busy, ucq_pop, flush_done,
                   e_pop, e_done);
        end
      end
      if (ucq_pop) npop++;
      if (flush_done) ndone++;
      g = req_ready[3];
      tick();
      if (g) req_lit[3] = W'($urandom);
    end
    checks++;
    if (npop != 5 || ndone != 1 || !resumed) begin
      failures++;
      $display("FAIL flush_summary: pops=%0d done=%0d resumed=%0d want 5 1 1",
               npop, ndone, resumed);
    end
    flush = 0;
    req_valid = '0;
  endtask

  task automatic test_reset_mid_drain();
    bit g;
    do_reset();
    req_valid = 4'b0001;
    req_lit[0] = W'($urandom);
    for (int c = 0; c < 5; c++) begin
      settle();
      g = req_ready[0];
      tick();
      if (g) req_lit[0] = W'($urandom);
    end
    req_valid = '0;
    flush = 1;
    settle();
    tick();
    flush = 0;
    settle();
    tick();
    rst = 1;
    settle();
    checks++;
    if ({req_ready, ucq_push, ucq_pop, flush_done, busy} !== '0) begin
      failures++;
      $display("FAIL rst_mid_comb: ready=%b push=%b pop=%b done=%b busy=%b want 0",
               req_ready, ucq_push, ucq_pop, flush_done, busy);
    end
    tick();
    rst = 0;
    settle();
    checks++;
    if (eng_valid !== 1'b0 || eng_lit !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state: ev=%b lit=%h busy=%b want 0 000 0",
               eng_valid, eng_lit, busy);
    end
    req_valid = 4'b0100;
    req_lit[2] = W'($urandom);
    settle();
    checks++;
    if (req_ready !== 4'b0100 || grant_id !== 2'd2
        || ucq_push !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_grant: ready=%b id=%0d push=%b want 0100 2 1",
               req_ready, grant_id, ucq_push);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    do_reset();
    for (int i = 0; i < N; i++) req_lit[i] = W'($urandom);
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      eng_ready = ($urandom_range(0, 3) != 0);
      settle();
      checks++;
      if (req_ready !== e_ready || ucq_push !== e_push
          || ucq_pop !== e_pop || flush_done !== e_done
          || busy !== e_busy) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: rdy=%b psh=%b pop=%b done=%b busy=%b want %b %b %b %b %b",
                 c, req_ready, ucq_push, ucq_pop, flush_done, busy,
                 e_ready, e_push, e_pop, e_done, e_busy);
      end
      checks++;
      if (eng_valid !== m_ev || eng_lit !== W'(m_el)) begin
        failures++;
        $display("FAIL rand_out[%0d]: ev=%b lit=%h want %b %h",
                 c, eng_valid, eng_lit, m_ev, W'(m_el));
      end
      if (e_push) begin
        checks++;
        if (ucq_data !== W'(e_data) || grant_id !== 2'(e_gid)) begin
          failures++;
          $display("FAIL rand_grant[%0d]: data=%h id=%0d want %h %0d",
                   c, ucq_data, grant_id, W'(e_data), e_gid);
        end
      end
      g = req_ready;
      tick();
      for (int i = 0; i < N; i++)
        if (g[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_lit[i] = W'($urandom);
        end
    end
    rst = 0; flush = 0; req_valid = '0;
  endtask

  initial begin
    rst = 1; req_valid = '0; flush = 0; eng_ready = 0;
    for (int i = 0; i < N; i++) req_lit[i] = '0;
    refresh();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_full();
    test_contested();
    test_latency();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
